ucode_sequencer: RTL and testbench
==================================

// Module: ucode_sequencer
// PURPOSE
//  Microcode sequencer driving the 32-bit control word consumed by the nqcpu datapath
//  (ALU/reg/mem control fields, mem strobes at bits [8:5]). Accepts an opcode dispatch address,
//  steps a micro-PC through a synchronous-read microcode ROM, emits one control word per cycle,
//  stalls on memory ops until mem_done, and returns to idle on an END micro-op.
// PARAMETERS
//  UPC_W   6   micro-PC / ROM address width
//  CW_W    32  control word width; bits [8:5] = {memReadB,memReadW,memWriteB,memWriteW}
// PORTS
//  clk            in   1          single clock, rising edge
//  reset          in   1          synchronous, active-high
//  op_valid       in   1          new instruction dispatch request
//  op_ready       out  1          sequencer idle, can accept dispatch
//  dispatch_addr  in   UPC_W      first micro-address for the instruction
//  rom_en         out  1          ROM read enable; ROM output holds when low
//  rom_addr       out  UPC_W      ROM read address
//  rom_data       in   CW_W+UPC_W+2  {cw[CW_W-1:0], next[UPC_W-1:0], seq[1:0]}, valid 1 cycle after rom_en
//  br_cond        in   1          branch condition from datapath flags
//  mem_done       in   1          memory op completes this cycle
//  ctrl_word      out  CW_W       current control word (0 when ctrl_valid=0)
//  ctrl_valid     out  1          ctrl_word is live
//  ctrl_commit    out  1          datapath commits ctrl_word this cycle
//  fault          out  1          watchdog fault (sticky; 0 when UCODE_WATCHDOG_EN undefined)
// BEHAVIOUR
//  States: IDLE, FETCH, EXEC. Reset (sync) -> IDLE, upc=0, all outputs 0 except op_ready=1.
//  IDLE: op_ready=1. op_valid&op_ready -> upc<=dispatch_addr, FETCH.
//  FETCH: rom_en=1, rom_addr=upc -> EXEC next cycle (1-cycle ROM latency).
//  EXEC: ctrl_valid=1, ctrl_word=rom_data.cw. mem_op = |cw[8:5].
//   - stall = mem_op & ~mem_done: rom_en=0, upc held, same word re-presented, ctrl_commit=0.
//   - otherwise ctrl_commit=1 and next upc by seq:
//     00 NEXT: upc+1 (mod 2^UPC_W, 0x3F->0x00)   01 JUMP: next
//     10 END: -> IDLE, rom_en=0                  11 BRANCH: br_cond ? next : upc+1
//   - non-END commit: rom_en=1, rom_addr=new upc same cycle; stay EXEC (1 word/cycle, no bubble).
//  After END: IDLE for >=1 cycle before next dispatch (op_ready=0 during FETCH/EXEC).
//  mem_done ignored outside EXEC or when mem_op=0. br_cond sampled only on BRANCH commit.
//  Reset mid-operation (incl. stall) wins over all: IDLE next cycle, ctrl_valid=0.
// CONFIGURATION
//  UCODE_WATCHDOG_EN defined: 8-bit counter counts consecutive stall cycles, clears on
//   commit/IDLE. On reaching 255: fault<=1 (sticky until reset), state->IDLE, ctrl_valid=0,
//   op_ready held 0 while fault=1.
//  Undefined: no counter, fault tied 0, stall lasts until mem_done indefinitely.
// TESTING
//  1 reset held 2 cycles -> op_ready=1, ctrl_valid=0, rom_en=0, fault=0.
//  2 dispatch 0x10; ROM[0x10]={A,x,NEXT},[0x11]={B,x,END} -> accept@T, rom_addr 0x10@T+1,
//    ctrl_word A@T+2, B@T+3, commit both, op_ready=1@T+4.
//  3 word cw[8]=1 (memReadB), mem_done high 3 cycles later -> word held 4 cycles, one commit.
//  4 BRANCH next=0x20 at 0x05: br_cond=1 -> rom_addr 0x20; br_cond=0 -> rom_addr 0x06;
//    NEXT at 0x3F -> rom_addr 0x00.
//  5 reset asserted during stall -> next cycle IDLE, ctrl_valid=0, op_ready=1.
//  6 (UCODE_WATCHDOG_EN) mem_done never asserted -> fault=1 after 255 stall cycles, op_ready=0
//    until reset; without macro word still held after 300 cycles, fault=0.

Source files
------------

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: steps a micro-PC through a synchronous-read ROM and emits one control word
// per cycle. Optional stall watchdog enabled by defining UCODE_WATCHDOG_EN.
module ucode_sequencer #(
  parameter int unsigned UPC_W = 6,
  parameter int unsigned CW_W  = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    op_valid_i,
  output logic                    op_ready_o,
  input  logic [UPC_W-1:0]        dispatch_addr_i,
  output logic                    rom_en_o,
  output logic [UPC_W-1:0]        rom_addr_o,
  input  logic [CW_W+UPC_W+1:0]   rom_data_i,
  input  logic                    br_cond_i,
  input  logic                    mem_done_i,
  output logic [CW_W-1:0]         ctrl_word_o,
  output logic                    ctrl_valid_o,
  output logic                    ctrl_commit_o,
  output logic                    fault_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  localparam logic [1:0] SeqNext   = 2'b00;
  localparam logic [1:0] SeqJump   = 2'b01;
  localparam logic [1:0] SeqEnd    = 2'b10;
  localparam logic [1:0] SeqBranch = 2'b11;

  state_e            state_q, state_d;
  logic [UPC_W-1:0]  upc_q, upc_d;

  logic [CW_W-1:0]   rom_cw;
  logic [UPC_W-1:0]  rom_next;
  logic [1:0]        rom_seq;
  logic [UPC_W-1:0]  upc_inc;
  logic              mem_op;

  assign rom_cw   = rom_data_i[CW_W+UPC_W+1:UPC_W+2];
  assign rom_next = rom_data_i[UPC_W+1:2];
  assign rom_seq  = rom_data_i[1:0];
  assign upc_inc  = upc_q + 1'b1;
  assign mem_op   = |rom_cw[8:5];

`ifdef UCODE_WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       fault_q, fault_d;
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    upc_d         = upc_q;
    op_ready_o    = 1'b0;
    rom_en_o      = 1'b0;
    rom_addr_o    = upc_q;
    ctrl_word_o   = '0;
    ctrl_valid_o  = 1'b0;
    ctrl_commit_o = 1'b0;
`ifdef UCODE_WATCHDOG_EN
    wd_cnt_d      = '0;
    fault_d       = fault_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef UCODE_WATCHDOG_EN
        op_ready_o = ~fault_q;
`else
        op_ready_o = 1'b1;
`endif
        if (op_valid_i && op_ready_o) begin
          upc_d   = dispatch_addr_i;
          state_d = StFetch;
        end
      end
      StFetch: begin
        rom_en_o = 1'b1;
        state_d  = StExec;
      end
      StExec: begin
        ctrl_valid_o = 1'b1;
        ctrl_word_o  = rom_cw;
        if (mem_op && !mem_done_i) begin
          // Stall: ROM output holds because rom_en stays low.
`ifdef UCODE_WATCHDOG_EN
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (wd_cnt_q == 8'd254) begin
            fault_d = 1'b1;
            state_d = StIdle;
          end
`endif
        end else begin
          ctrl_commit_o = 1'b1;
          case (rom_seq)
            SeqNext:   upc_d = upc_inc;
            SeqJump:   upc_d = rom_next;
            SeqBranch: upc_d = br_cond_i ? rom_next : upc_inc;
            default:   state_d = StIdle;
          endcase
          // Fetch the following word in the same cycle so words issue back to back.
          if (rom_seq != SeqEnd) begin
            rom_en_o   = 1'b1;
            rom_addr_o = upc_d;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      upc_q    <= '0;
`ifdef UCODE_WATCHDOG_EN
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      upc_q    <= upc_d;
`ifdef UCODE_WATCHDOG_EN
      wd_cnt_q <= wd_cnt_d;
      fault_q  <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: ROM model, table-driven programs, commit scoreboard.
module tb_ucode_sequencer;
  localparam int UPC_W = 6;
  localparam int CW_W  = 32;
  localparam int RW    = CW_W + UPC_W + 2;

  localparam logic [1:0] SqNext = 2'b00, SqJump = 2'b01, SqEnd = 2'b10, SqBr = 2'b11;

  localparam logic [31:0] WA = 32'hA1A1_0000, WB = 32'hB2B2_0000, WC = 32'hC3C3_0000;
  localparam logic [31:0] WD = 32'hD4D4_0000, WE = 32'hE5E5_0000, WF = 32'hF6F6_0000;
  localparam logic [31:0] WG = 32'h1717_0000, WH = 32'h2828_0000, WI = 32'h3939_0000;
  localparam logic [31:0] WM = 32'h4A4A_0100;  // memReadB set

  logic             clk = 1'b0;
  logic             reset, op_valid, op_ready, rom_en, br_cond, mem_done;
  logic             ctrl_valid, ctrl_commit, fault;
  logic [UPC_W-1:0] dispatch_addr, rom_addr;
  logic [RW-1:0]    rom_data;
  logic [CW_W-1:0]  ctrl_word;

  logic [RW-1:0]    rom_mem [64];
  logic [RW-1:0]    rom_q;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [31:0]      exp_q [$];
  logic [31:0]      sb_w;

  typedef struct {
    logic [5:0]  disp;
    logic        br;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [5:0]  addr1;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  ucode_sequencer #(.UPC_W(UPC_W), .CW_W(CW_W)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .op_valid_i      (op_valid),
    .op_ready_o      (op_ready),
    .dispatch_addr_i (dispatch_addr),
    .rom_en_o        (rom_en),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .br_cond_i       (br_cond),
    .mem_done_i      (mem_done),
    .ctrl_word_o     (ctrl_word),
    .ctrl_valid_o    (ctrl_valid),
    .ctrl_commit_o   (ctrl_commit),
    .fault_o         (fault)
  );

  always @(posedge clk) if (rom_en) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_q;

  // Scoreboard: every commit must match the oldest expected word.
  always @(negedge clk) begin
    if (ctrl_commit) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_commit: actual %h required no commit", ctrl_word);
      end else begin
        sb_w = exp_q.pop_front();
        if (ctrl_word !== sb_w) begin
          n_bad++;
          $display("FAIL sb_commit_word: actual %h required %h", ctrl_word, sb_w);
        end
      end
    end
  end

  function automatic logic [RW-1:0] ent(input logic [31:0] cw, input logic [5:0] nx,
                                        input logic [1:0] sq);
    return {cw, nx, sq};
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!op_ready && k < 20) begin
      tick();
      k++;
    end
    chk("idle_ready", op_ready, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    wait_ready();
    op_valid      = 1'b1;
    dispatch_addr = v.disp;
    br_cond       = v.br;
    exp_q.push_back(v.w0);
    if (v.n == 2) exp_q.push_back(v.w1);
    tick();
    op_valid = 1'b0;
    #1;
    chk("fetch_rom_en", rom_en, 1);
    chk("fetch_rom_addr", rom_addr, v.disp);
    chk("fetch_not_ready", op_ready, 0);
    tick();
    chk("exec0_word", ctrl_word, v.w0);
    chk("exec0_valid", ctrl_valid, 1);
    if (v.n == 2) begin
      chk("exec0_next_addr", rom_addr, v.addr1);
      chk("exec0_next_en", rom_en, 1);
      tick();
      chk("exec1_word", ctrl_word, v.w1);
    end
    tick();
    chk("done_ready", op_ready, 1);
    chk("done_valid", ctrl_valid, 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual timeout required $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = '0;
    rom_mem[6'h10] = ent(WA, 6'h2A, SqNext);
    rom_mem[6'h11] = ent(WB, 6'h00, SqEnd);
    rom_mem[6'h05] = ent(WC, 6'h20, SqBr);
    rom_mem[6'h20] = ent(WD, 6'h00, SqEnd);
    rom_mem[6'h06] = ent(WE, 6'h00, SqEnd);
    rom_mem[6'h3F] = ent(WF, 6'h15, SqNext);
    rom_mem[6'h00] = ent(WG, 6'h00, SqEnd);
    rom_mem[6'h30] = ent(WH, 6'h12, SqJump);
    rom_mem[6'h12] = ent(WI, 6'h00, SqEnd);
    rom_mem[6'h08] = ent(WM, 6'h00, SqEnd);
    rom_q = '0;

    vecs[0] = '{6'h10, 1'b0, 2, WA, WB, 6'h11};
    vecs[1] = '{6'h05, 1'b1, 2, WC, WD, 6'h20};
    vecs[2] = '{6'h05, 1'b0, 2, WC, WE, 6'h06};
    vecs[3] = '{6'h3F, 1'b0, 2, WF, WG, 6'h00};
    vecs[4] = '{6'h30, 1'b0, 2, WH, WI, 6'h12};
    vecs[5] = '{6'h20, 1'b1, 1, WD, 32'h0, 6'h00};

    op_valid = 1'b0; dispatch_addr = '0; br_cond = 1'b0; mem_done = 1'b0;
    do_reset();
    chk("rst_ready", op_ready, 1);
    chk("rst_valid", ctrl_valid, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_fault", fault, 0);
    chk("rst_word", ctrl_word, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Memory stall: word held for 4 cycles, single commit when mem_done arrives.
    wait_ready();
    op_valid = 1'b1; dispatch_addr = 6'h08;
    exp_q.push_back(WM);
    tick();
    op_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall_word", ctrl_word, WM);
      chk("stall_commit", ctrl_commit, 0);
      chk("stall_rom_en", rom_en, 0);
      tick();
    end
    mem_done = 1'b1;
    #1;
    chk("stall_release_commit", ctrl_commit, 1);
    chk("stall_release_word", ctrl_word, WM);
    tick();
    mem_done = 1'b0;
    #1;
    chk("stall_done_ready", op_ready, 1);
    chk("stall_sb_drained", exp_q.size(), 0);

    // Reset wins during a stall.
    wait_ready();
    op_valid = 1'b1; dispatch_addr = 6'h08;
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_stall_valid", ctrl_valid, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", ctrl_valid, 0);
    chk("mid_rst_ready", op_ready, 1);
    reset = 1'b0;

    // Long stall: watchdog trip, or indefinite hold without the watchdog.
    wait_ready();
    op_valid = 1'b1; dispatch_addr = 6'h08;
    tick();
    op_valid = 1'b0;
    tick();
`ifdef UCODE_WATCHDOG_EN
    begin
      int cnt = 0;
      while (!fault && cnt < 400) begin
        cnt++;
        tick();
      end
      chk("wd_stall_cycles", cnt, 255);
      chk("wd_fault", fault, 1);
      chk("wd_valid", ctrl_valid, 0);
      op_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk("wd_ready_low", op_ready, 0);
        chk("wd_no_fetch", rom_en, 0);
        tick();
      end
      op_valid = 1'b0;
    end
`else
    repeat (300) tick();
    chk("long_stall_word", ctrl_word, WM);
    chk("long_stall_valid", ctrl_valid, 1);
    chk("long_stall_commit", ctrl_commit, 0);
    chk("long_stall_fault", fault, 0);
`endif
    do_reset();
    chk("post_rst_fault", fault, 0);
    chk("post_rst_ready", op_ready, 1);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
